// File: rtl/scalar_wb_queue.sv
// Scalar writeback queue: arbitrates ALU/load results into an in-order FIFO that drives the RF write port.
// Optional decode forwarding search is enabled by defining SCALAR_WB_FWD_EN.
module scalar_wb_queue #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned VW    = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [4:0]              alu_rd,
    input  logic [WIDTH-1:0]        alu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [4:0]              mem_rd,
    input  logic [WIDTH-1:0]        mem_data,
    input  logic                    wb_stall,
    output logic [4:0]              RD,
    output logic [VW-1:0]           WD,
    output logic                    WES,
    output logic [$clog2(DEPTH):0]  count
`ifdef SCALAR_WB_FWD_EN
    ,
    input  logic [4:0]              fwd_rs,
    output logic                    fwd_hit,
    output logic [WIDTH-1:0]        fwd_data
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic {
        PRI_ALU = 1'b0,
        PRI_MEM = 1'b1
    } pri_e;

    logic [4:0]       rd_mem_q  [DEPTH];
    logic [WIDTH-1:0] dat_mem_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    pri_e          rr_q, rr_d;

    logic             pop;
    logic             room;
    logic             contended;
    logic             alu_gnt;
    logic             mem_gnt;
    logic             accept;
    logic             push;
    logic [4:0]       in_rd;
    logic [WIDTH-1:0] in_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rr_q    <= PRI_MEM;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rr_q    <= rr_d;
        end
    end

    // Payload storage needs no reset: only slots inside [head, head+count) are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem_q[tail_q]  <= in_rd;
            dat_mem_q[tail_q] <= in_data;
        end
    end

    always_comb begin
        pop       = (count_q != '0) && !wb_stall;
        room      = (count_q < FULL_CNT) || pop;
        contended = alu_valid && mem_valid;
        alu_gnt   = alu_valid && (!mem_valid || (rr_q == PRI_ALU));
        mem_gnt   = mem_valid && (!alu_valid || (rr_q == PRI_MEM));
        alu_ready = rst && alu_gnt && room;
        mem_ready = rst && mem_gnt && room;
        accept    = alu_ready || mem_ready;
        in_rd     = mem_ready ? mem_rd : alu_rd;
        in_data   = mem_ready ? mem_data : alu_data;
        // Writes to R0 complete the handshake but never occupy a slot.
        push      = accept && (in_rd != 5'd0);

        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push) - CW'(pop);

        rr_d = rr_q;
        if (accept && contended) begin
            rr_d = (rr_q == PRI_MEM) ? PRI_ALU : PRI_MEM;
        end

        WES = pop;
        RD  = '0;
        WD  = '0;
        if (pop) begin
            RD                = rd_mem_q[head_q];
            WD[VW-1 -: WIDTH] = dat_mem_q[head_q];
        end
    end

    assign count = count_q;

`ifdef SCALAR_WB_FWD_EN
    logic [PW-1:0] fwd_idx;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = head_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (fwd_rs != 5'd0) && (rd_mem_q[fwd_idx] == fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = dat_mem_q[fwd_idx];
            end
        end
    end
`endif

endmodule

// File: tb/tb_scalar_wb_queue.sv
// Directed self-checking bench for scalar_wb_queue (forwarding checks compiled with SCALAR_WB_FWD_EN).
module tb_scalar_wb_queue;

    logic         clk;
    logic         rst;
    logic         alu_valid;
    logic         alu_ready;
    logic [4:0]   alu_rd;
    logic [15:0]  alu_data;
    logic         mem_valid;
    logic         mem_ready;
    logic [4:0]   mem_rd;
    logic [15:0]  mem_data;
    logic         wb_stall;
    logic [4:0]   RD;
    logic [255:0] WD;
    logic         WES;
    logic [2:0]   count;
    logic [4:0]   fwd_rs;
    logic         fwd_hit;
    logic [15:0]  fwd_data;

    int unsigned n_checks;
    int unsigned n_fail;

    scalar_wb_queue #(.WIDTH(16), .DEPTH(4), .VW(256)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .wb_stall  (wb_stall),
        .RD        (RD),
        .WD        (WD),
        .WES       (WES),
        .count     (count)
`ifdef SCALAR_WB_FWD_EN
        ,
        .fwd_rs    (fwd_rs),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] wd_of(input logic [15:0] d);
        return {d, 240'h0};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 16'h1111;
        mem_valid = 1'b1;
        mem_rd    = 5'd4;
        mem_data  = 16'h2222;
        wb_stall  = 1'b0;
        fwd_rs    = 5'd0;

        // Reset state, valids asserted during reset
        #1;
        check("rst_wes", 256'(WES), 256'd0);
        check("rst_rd", 256'(RD), 256'd0);
        check("rst_wd", WD, 256'd0);
        check("rst_count", 256'(count), 256'd0);
        check("rst_alu_rdy", 256'(alu_ready), 256'd0);
        check("rst_mem_rdy", 256'(mem_ready), 256'd0);
        next_cycle();
        next_cycle();
        rst       = 1'b1;
        alu_valid = 1'b0;
        mem_valid = 1'b0;

        // Test 1: async reset with 3 pending entries
        wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1'b1;
            alu_rd    = 5'(i + 1);
            alu_data  = 16'(16'h0A00 + i);
            next_cycle();
        end
        alu_valid = 1'b0;
        check("t1_count3", 256'(count), 256'd3);
        wb_stall = 1'b0;
        #1;
        check("t1_wes_pre", 256'(WES), 256'd1);
        rst = 1'b0;
        #1;
        check("t1_wes_async", 256'(WES), 256'd0);
        check("t1_count_async", 256'(count), 256'd0);
        next_cycle();
        rst       = 1'b1;
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 16'h1234;
        #1;
        check("t1_alu_rdy", 256'(alu_ready), 256'd1);
        next_cycle();
        alu_valid = 1'b0;
        #1;
        check("t1_wes", 256'(WES), 256'd1);
        check("t1_rd", 256'(RD), 256'd5);
        check("t1_wd", WD, wd_of(16'h1234));
        check("t1_count1", 256'(count), 256'd1);
        next_cycle();
        check("t1_wes_off", 256'(WES), 256'd0);
        check("t1_count0", 256'(count), 256'd0);

        // Test 2: contention, MEM first then alternating
        begin
            int a;
            int m;
            logic mg;
            a = 0;
            m = 0;
            for (int i = 0; i < 4; i++) begin
                mg        = (i % 2 == 0);
                alu_valid = 1'b1;
                mem_valid = 1'b1;
                alu_rd    = 5'(10 + a);
                alu_data  = 16'(16'hA000 + a);
                mem_rd    = 5'(20 + m);
                mem_data  = 16'(16'hB000 + m);
                #1;
                check("t2_mem_rdy", 256'(mem_ready), 256'(mg));
                check("t2_alu_rdy", 256'(alu_ready), 256'(!mg));
                next_cycle();
                check("t2_wes", 256'(WES), 256'd1);
                check("t2_rd", 256'(RD), mg ? 256'(20 + m) : 256'(10 + a));
                check("t2_wd", WD, mg ? wd_of(16'(16'hB000 + m)) : wd_of(16'(16'hA000 + a)));
                check("t2_count", 256'(count), 256'd1);
                if (mg) m++;
                else a++;
            end
            alu_valid = 1'b0;
            mem_valid = 1'b0;
            next_cycle();
            check("t2_drained", 256'(count), 256'd0);
        end

        // Test 3: fill under stall, then push while popping a full FIFO
        wb_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1;
            alu_rd    = 5'(1 + i);
            alu_data  = 16'(16'h0100 + i);
            #1;
            check("t3_fill_rdy", 256'(alu_ready), 256'd1);
            next_cycle();
        end
        check("t3_count4", 256'(count), 256'd4);
        alu_rd   = 5'd5;
        alu_data = 16'h0104;
        #1;
        check("t3_full_rdy", 256'(alu_ready), 256'd0);
        check("t3_full_wes", 256'(WES), 256'd0);
        next_cycle();
        check("t3_hold_count", 256'(count), 256'd4);
        wb_stall = 1'b0;
        #1;
        check("t3_pp_rdy", 256'(alu_ready), 256'd1);
        check("t3_pp_wes", 256'(WES), 256'd1);
        check("t3_pp_rd", 256'(RD), 256'd1);
        check("t3_pp_wd", WD, wd_of(16'h0100));
        next_cycle();
        alu_valid = 1'b0;
        check("t3_pp_count", 256'(count), 256'd4);
        for (int j = 0; j < 4; j++) begin
            check("t3_drain_wes", 256'(WES), 256'd1);
            check("t3_drain_rd", 256'(RD), 256'(2 + j));
            check("t3_drain_wd", WD, wd_of(16'(16'h0101 + j)));
            next_cycle();
            check("t3_drain_count", 256'(count), 256'(3 - j));
        end
        check("t3_empty_wes", 256'(WES), 256'd0);

        // Test 4: R0 write is accepted and discarded
        mem_valid = 1'b1;
        mem_rd    = 5'd0;
        mem_data  = 16'hFFFF;
        #1;
        check("t4_mem_rdy", 256'(mem_ready), 256'd1);
        next_cycle();
        mem_valid = 1'b0;
        check("t4_count", 256'(count), 256'd0);
        check("t4_wes", 256'(WES), 256'd0);
        next_cycle();
        check("t4_wes2", 256'(WES), 256'd0);

`ifdef SCALAR_WB_FWD_EN
        // Test 5: youngest-match forwarding
        wb_stall  = 1'b1;
        alu_valid = 1'b1;
        alu_rd    = 5'd7;
        alu_data  = 16'h0001;
        next_cycle();
        alu_data  = 16'h0002;
        next_cycle();
        alu_valid = 1'b0;
        fwd_rs    = 5'd7;
        #1;
        check("t5_hit", 256'(fwd_hit), 256'd1);
        check("t5_data", 256'(fwd_data), 256'h0002);
        fwd_rs = 5'd0;
        #1;
        check("t5_r0_hit", 256'(fwd_hit), 256'd0);
        fwd_rs = 5'd3;
        #1;
        check("t5_miss_hit", 256'(fwd_hit), 256'd0);
        check("t5_miss_data", 256'(fwd_data), 256'd0);
        wb_stall = 1'b0;
        next_cycle();
        next_cycle();
        check("t5_drained", 256'(count), 256'd0);
`endif

        // Test 6: back-to-back ALU pushes with no stall
        for (int i = 0; i < 10; i++) begin
            alu_valid = 1'b1;
            alu_rd    = 5'(1 + i);
            alu_data  = 16'(16'h2000 + i);
            #1;
            check("t6_rdy", 256'(alu_ready), 256'd1);
            check("t6_cnt_le1", 256'(count <= 3'd1), 256'd1);
            if (i > 0) begin
                check("t6_wes", 256'(WES), 256'd1);
                check("t6_rd", 256'(RD), 256'(i));
                check("t6_wd", WD, wd_of(16'(16'h2000 + i - 1)));
            end
            next_cycle();
        end
        alu_valid = 1'b0;
        check("t6_last_wes", 256'(WES), 256'd1);
        check("t6_last_rd", 256'(RD), 256'd10);
        check("t6_last_wd", WD, wd_of(16'h2009));
        next_cycle();
        check("t6_end_count", 256'(count), 256'd0);
        check("t6_end_wes", 256'(WES), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
